// File: rtl/csr_file_m_if.sv
// Execute-stage <-> machine-mode CSR file connection: Zicsr access, trap redirect,
// retire and interrupt qualifiers.
interface csr_file_m_if #(
  parameter int unsigned XLEN = 64
);
  logic [2:0]      csr_op;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] pc;
  logic            retire;
  logic            timer_irq;
  logic            irq_ok;
  logic [XLEN-1:0] rdata;
  logic            trap_valid;
  logic [XLEN-1:0] trap_target;
  logic            illegal;

  modport master (
    output csr_op, csr_addr, wdata, pc, retire, timer_irq, irq_ok,
    input  rdata, trap_valid, trap_target, illegal
  );

  modport slave (
    input  csr_op, csr_addr, wdata, pc, retire, timer_irq, irq_ok,
    output rdata, trap_valid, trap_target, illegal
  );
endinterface

// File: rtl/csr_file_m.sv
// Machine-mode CSR file: Zicsr RW/RS/RC, ECALL/MRET trap sequencing, gated machine-timer
// interrupt and free-running mcycle/minstret. Reads are combinational.
module csr_file_m #(
  parameter int unsigned     XLEN         = 64,
  parameter bit              HAS_COUNTERS = 1'b1,
  parameter logic [XLEN-1:0] MTVEC_RESET  = '0
) (
  input logic         clk,
  input logic         rst,
  csr_file_m_if.slave bus
);

  localparam logic [2:0] OpNone  = 3'b000;
  localparam logic [2:0] OpRw    = 3'b001;
  localparam logic [2:0] OpRs    = 3'b010;
  localparam logic [2:0] OpRc    = 3'b011;
  localparam logic [2:0] OpEcall = 3'b100;
  localparam logic [2:0] OpMret  = 3'b101;

  localparam logic [11:0] AddrMstatus  = 12'h300;
  localparam logic [11:0] AddrMie      = 12'h304;
  localparam logic [11:0] AddrMtvec    = 12'h305;
  localparam logic [11:0] AddrMscratch = 12'h340;
  localparam logic [11:0] AddrMepc     = 12'h341;
  localparam logic [11:0] AddrMcause   = 12'h342;
  localparam logic [11:0] AddrMip      = 12'h344;
  localparam logic [11:0] AddrMcycle   = 12'hB00;
  localparam logic [11:0] AddrMinstret = 12'hB02;

  localparam logic [XLEN-1:0] CauseEcall = XLEN'(11);
  localparam logic [XLEN-1:0] CauseTimer = {1'b1, {(XLEN-5){1'b0}}, 4'd7};
  localparam logic [XLEN-1:0] One        = XLEN'(1);

  // Architectural state; only the writable fields of mstatus/mie are stored.
  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic            mtie_q, mtie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mcycle_q;
  logic [XLEN-1:0] minstret_q;

  logic            is_rmw, is_ecall, is_mret, is_none;
  logic            hit, csr_wr, irq_take;
  logic [XLEN-1:0] old_val, new_val;
  logic [XLEN-1:0] mstatus_rd, mie_rd, mip_rd;

  always_comb begin
    is_rmw   = (bus.csr_op == OpRw) || (bus.csr_op == OpRs) || (bus.csr_op == OpRc);
    is_ecall = (bus.csr_op == OpEcall);
    is_mret  = (bus.csr_op == OpMret);
    // Reserved encodings 110/111 behave exactly like NONE, including for interrupts.
    is_none  = !(is_rmw || is_ecall || is_mret);
  end

  always_comb begin
    mstatus_rd        = '0;
    mstatus_rd[12:11] = 2'b11;
    mstatus_rd[7]     = mpie_q;
    mstatus_rd[3]     = mie_q;
    mie_rd            = '0;
    mie_rd[7]         = mtie_q;
    mip_rd            = '0;
    mip_rd[7]         = bus.timer_irq;
  end

  always_comb begin
    hit     = 1'b0;
    old_val = '0;
    case (bus.csr_addr)
      AddrMstatus:  begin hit = 1'b1; old_val = mstatus_rd; end
      AddrMie:      begin hit = 1'b1; old_val = mie_rd;     end
      AddrMtvec:    begin hit = 1'b1; old_val = mtvec_q;    end
      AddrMscratch: begin hit = 1'b1; old_val = mscratch_q; end
      AddrMepc:     begin hit = 1'b1; old_val = mepc_q;     end
      AddrMcause:   begin hit = 1'b1; old_val = mcause_q;   end
      AddrMip:      begin hit = 1'b1; old_val = mip_rd;     end
      AddrMcycle:   begin hit = HAS_COUNTERS; old_val = mcycle_q;   end
      AddrMinstret: begin hit = HAS_COUNTERS; old_val = minstret_q; end
      default: ;
    endcase
  end

  always_comb begin
    case (bus.csr_op)
      OpRs:    new_val = old_val | bus.wdata;
      OpRc:    new_val = old_val & ~bus.wdata;
      default: new_val = bus.wdata;
    endcase
    // Set/clear with a zero operand is a pure read.
    csr_wr   = is_rmw && hit && ((bus.csr_op == OpRw) || (bus.wdata != '0));
    irq_take = is_none && bus.irq_ok && mie_q && mtie_q && bus.timer_irq;
  end

  always_comb begin
    bus.rdata       = (is_rmw && hit) ? old_val : '0;
    bus.illegal     = is_rmw && !hit;
    bus.trap_valid  = is_ecall || is_mret || irq_take;
    bus.trap_target = '0;
    if (is_ecall || irq_take) begin
      bus.trap_target = mtvec_q;
    end else if (is_mret) begin
      bus.trap_target = mepc_q;
    end
  end

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtie_d     = mtie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;

    if (csr_wr) begin
      case (bus.csr_addr)
        AddrMstatus: begin
          mie_d  = new_val[3];
          mpie_d = new_val[7];
        end
        AddrMie:      mtie_d     = new_val[7];
        AddrMtvec:    mtvec_d    = {new_val[XLEN-1:2], 2'b00};
        AddrMscratch: mscratch_d = new_val;
        AddrMepc:     mepc_d     = {new_val[XLEN-1:2], 2'b00};
        AddrMcause:   mcause_d   = new_val;
        default: ;
      endcase
    end

    if (is_ecall || irq_take) begin
      mepc_d   = {bus.pc[XLEN-1:2], 2'b00};
      mcause_d = is_ecall ? CauseEcall : CauseTimer;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (is_mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtie_q     <= 1'b0;
      mtvec_q    <= {MTVEC_RESET[XLEN-1:2], 2'b00};
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtie_q     <= mtie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

  if (HAS_COUNTERS) begin : g_counters
    logic [XLEN-1:0] mcycle_d, minstret_d;

    // A software write replaces that cycle's increment.
    always_comb begin
      mcycle_d   = mcycle_q + One;
      minstret_d = minstret_q + {{(XLEN-1){1'b0}}, bus.retire};
      if (csr_wr && (bus.csr_addr == AddrMcycle)) begin
        mcycle_d = new_val;
      end
      if (csr_wr && (bus.csr_addr == AddrMinstret)) begin
        minstret_d = new_val;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        mcycle_q   <= '0;
        minstret_q <= '0;
      end else begin
        mcycle_q   <= mcycle_d;
        minstret_q <= minstret_d;
      end
    end
  end else begin : g_no_counters
    assign mcycle_q   = '0;
    assign minstret_q = '0;
  end

endmodule
